ps2_keycode_rx: RTL

//  Keyboard front end that produces the 8-bit keycode consumed by the Player movement logic and game FSM.

---
 rtl/kbd_pkg.sv | 38 +++
 rtl/ps2_frame_rx.sv | 125 ++++++++++++
 rtl/ps2_keycode_rx.sv | 84 ++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// Shared PS/2 keyboard types and constants: receive FSM states, set-2 prefixes
// and the scan-code to HID usage map.
package kbd_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  localparam logic [7:0] KEY_NONE  = 8'd0;
  localparam logic [7:0] KEY_W     = 8'd26;
  localparam logic [7:0] KEY_A     = 8'd4;
  localparam logic [7:0] KEY_S     = 8'd22;
  localparam logic [7:0] KEY_D     = 8'd7;
  localparam logic [7:0] KEY_SPACE = 8'd44;
  localparam logic [7:0] KEY_ENTER = 8'd40;

  // KEY_NONE marks a scan code the game does not care about.
  function automatic logic [7:0] scan_to_hid(input logic [7:0] sc);
    case (sc)
      SC_W:     scan_to_hid = KEY_W;
      SC_A:     scan_to_hid = KEY_A;
      SC_S:     scan_to_hid = KEY_S;
      SC_D:     scan_to_hid = KEY_D;
      SC_SPACE: scan_to_hid = KEY_SPACE;
      SC_ENTER: scan_to_hid = KEY_ENTER;
      default:  scan_to_hid = KEY_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronisers, clock glitch filter,
// 11-bit frame FSM with odd parity check and mid-frame timeout.
module ps2_frame_rx
  import kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FW-1:0] FCNT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TCNT_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_s, dat_s;
  logic          filt;
  logic [FW-1:0] fcnt;
  logic          flip, fall;

  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_ok;
  logic [TW-1:0] tcnt;

  // Lines idle high, so the synchronisers and filter come out of reset at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
    end
  end

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  // The sample that completes a run of FILTER_LEN new-level samples is the edge.
  assign flip = (clk_s != filt) && (fcnt == FCNT_MAX);
  assign fall = flip && filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= 1'b1;
      fcnt <= '0;
    end else if (clk_s == filt) begin
      fcnt <= '0;
    end else if (flip) begin
      filt <= clk_s;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RX_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_ok     <= 1'b0;
      tcnt       <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        case (state)
          RX_IDLE: begin
            if (!dat_s) begin
              state   <= RX_DATA;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          RX_DATA: begin
            shreg   <= {dat_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
            par_ok <= ^{shreg, dat_s};
            state  <= RX_STOP;
          end
          RX_STOP: begin
            if (dat_s && par_ok) begin
              byte_valid <= 1'b1;
              rx_byte    <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
            state <= RX_IDLE;
          end
          default: state <= RX_IDLE;
        endcase
      end else if (state != RX_IDLE) begin
        if (tcnt == TCNT_MAX) begin
          frame_err <= 1'b1;
          state     <= RX_IDLE;
          tcnt      <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_keycode_rx.sv
// Keyboard front end: turns received set-2 bytes into the HID usage of the
// most recently pressed, still-held game key (0 when none is held).
module ps2_keycode_rx
  import kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] keycode,
  output logic       key_event,
  output logic       frame_err,
  output logic [7:0] scan_code
);

  logic [1:0] rst_sync;
  logic       rst_int;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       brk, ext;
  logic [7:0] hid;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int = rst_sync[1];

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame (
    .clk       (Clk),
    .rst_n     (rst_int),
    .ps2_clk   (PS2_CLK),
    .ps2_dat   (PS2_DAT),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  assign hid = scan_to_hid(rx_byte);

  always_ff @(posedge Clk or negedge rst_int) begin
    if (!rst_int) begin
      keycode   <= KEY_NONE;
      key_event <= 1'b0;
      scan_code <= '0;
      brk       <= 1'b0;
      ext       <= 1'b0;
    end else begin
      key_event <= 1'b0;
      if (byte_valid) begin
        scan_code <= rx_byte;
        if (rx_byte == PS2_BREAK) begin
          brk <= 1'b1;
        end else if (rx_byte == PS2_EXT) begin
          ext <= 1'b1;
        end else begin
          // Extended keys share set-2 codes with game keys but are never mapped.
          if (!ext && hid != KEY_NONE) begin
            if (!brk) begin
              if (hid != keycode) begin
                keycode   <= hid;
                key_event <= 1'b1;
              end
            end else if (hid == keycode) begin
              keycode   <= KEY_NONE;
              key_event <= 1'b1;
            end
          end
          brk <= 1'b0;
          ext <= 1'b0;
        end
      end
    end
  end

endmodule
